jamma_input_scanner: RTL and testbench

JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

---
 rtl/jamma_pkg.sv | 16 +
 rtl/jamma_bit_debounce.sv | 53 +++++
 rtl/jamma_input_scanner.sv | 91 +++++++++
 tb/tb_jamma_input_scanner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA input scanner: scan states, select-width
// helper and the released (all ones) joystick pattern.
package jamma_pkg;

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_SAMPLE = 1'b1
   } scan_state_e;

   localparam logic [7:0] JOY_RELEASED = 8'hFF;

   function automatic int sel_w(input int num_players);
      return (num_players > 1) ? $clog2(num_players) : 1;
   endfunction

endpackage

// File: rtl/jamma_bit_debounce.sv
// Eight-bit debouncer for one JAMMA player: a bit flips only after
// DEBOUNCE_SCANS consecutive samples that disagree with its current value.
module jamma_bit_debounce
   import jamma_pkg::*;
#(
   parameter int  DEBOUNCE_SCANS = 3,
   localparam int DB_W           = $clog2(DEBOUNCE_SCANS + 1)
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       upd_i,
   input  logic [7:0] raw_i,
   output logic [7:0] joy_o
);

   localparam logic [DB_W-1:0] LAST_MISS = DB_W'(DEBOUNCE_SCANS - 1);

   logic [7:0]      joy_q, joy_d;
   logic [DB_W-1:0] cnt_q [8];
   logic [DB_W-1:0] cnt_d [8];

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      joy_d = joy_q;
      cnt_d = cnt_q;
      if (upd_i) begin
         for (int b = 0; b < 8; b++) begin
            if (raw_i[b] == joy_q[b]) begin
               cnt_d[b] = '0;
            end else if (cnt_q[b] == LAST_MISS) begin
               joy_d[b] = raw_i[b];
               cnt_d[b] = '0;
            end else begin
               cnt_d[b] = cnt_q[b] + DB_W'(1);
            end
         end
      end
   end

   // NOTE: the counter array is plain flops, not RAM, so it is reset along with the rest of the state.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         joy_q <= JOY_RELEASED;
         for (int b = 0; b < 8; b++) cnt_q[b] <= '0;
      end else begin
         joy_q <= joy_d;
         cnt_q <= cnt_d;
      end
   end

   assign joy_o = joy_q;

endmodule

// File: rtl/jamma_input_scanner.sv
// Time-multiplexed JAMMA player scanner merging keyboard joystick bits.
// Define JAMMA_INPUT_DEBOUNCE_EN to add per-bit debouncing.
module jamma_input_scanner
   import jamma_pkg::*;
#(
   parameter int  NUM_PLAYERS    = 2,
   parameter int  SETTLE_CYCLES  = 2,
   parameter int  DEBOUNCE_SCANS = 3,
   localparam int SEL_W          = sel_w(NUM_PLAYERS)
) (
   input  logic                     pclk,
   input  logic                     reset,
   input  logic                     ena_i,
   input  logic [7:0]               jjoy_i,
   input  logic [NUM_PLAYERS*8-1:0] kbd_joy_i,
   output logic [SEL_W-1:0]         jselect_o,
   output logic [NUM_PLAYERS*8-1:0] joy_o,
   output logic                     scan_done_o
);

   localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_P   = SEL_W'(NUM_PLAYERS - 1);

   scan_state_e      state_q;
   logic [SEL_W-1:0] p_q;
   logic [CNT_W-1:0] cnt_q;
   logic             scan_done_q;
   logic [7:0]       raw;
   logic             sample_fire;

   assign raw         = jjoy_i & kbd_joy_i[8*p_q +: 8];
   assign sample_fire = ena_i && (state_q == ST_SAMPLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_SETTLE;
         p_q         <= '0;
         cnt_q       <= '0;
         scan_done_q <= 1'b0;
      end else if (ena_i) begin
         scan_done_q <= 1'b0;
         case (state_q)
            ST_SETTLE: begin
               if (cnt_q == LAST_CNT) state_q <= ST_SAMPLE;
               else                   cnt_q   <= cnt_q + CNT_W'(1);
            end
            ST_SAMPLE: begin
               cnt_q   <= '0;
               state_q <= ST_SETTLE;
               if (p_q == LAST_P) begin
                  p_q         <= '0;
                  scan_done_q <= 1'b1;
               end else begin
                  p_q <= p_q + SEL_W'(1);
               end
            end
            default: state_q <= ST_SETTLE;
         endcase
      end
   end

   assign jselect_o = p_q;
   // The pulse is held while disabled and shown on the next enabled cycle.
   assign scan_done_o = scan_done_q & ena_i;

`ifdef JAMMA_INPUT_DEBOUNCE_EN
   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_db
      jamma_bit_debounce #(
         .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_db (
         .pclk  (pclk),
         .reset (reset),
         .upd_i (sample_fire && (p_q == SEL_W'(g))),
         .raw_i (raw),
         .joy_o (joy_o[8*g +: 8])
      );
   end
`else
   logic [NUM_PLAYERS*8-1:0] joy_q;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset)            joy_q                <= {NUM_PLAYERS{JOY_RELEASED}};
      else if (sample_fire) joy_q[8*p_q +: 8] <= raw;
   end

   assign joy_o = joy_q;
`endif

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Directed and randomized checks of jamma_input_scanner against a
// scan-arithmetic reference model (NUM_PLAYERS=2, SETTLE_CYCLES=2).
module tb_jamma_input_scanner;

   localparam int N = 2;
   localparam int S = 2;
   localparam int D = 3;
`ifdef JAMMA_INPUT_DEBOUNCE_EN
   localparam int DEFF  = D;
   localparam bit DB_EN = 1'b1;
`else
   localparam int DEFF  = 1;
   localparam bit DB_EN = 1'b0;
`endif
   localparam int SLOT = S + 1;
   localparam int SCAN = N * SLOT;

   logic            pclk = 1'b0;
   logic            reset;
   logic            ena_i;
   logic [7:0]      jjoy_i;
   logic [N*8-1:0]  kbd_joy_i;
   logic            jselect_o;
   logic [N*8-1:0]  joy_o;
   logic            scan_done_o;

   jamma_input_scanner #(
      .NUM_PLAYERS   (N),
      .SETTLE_CYCLES (S),
      .DEBOUNCE_SCANS(D)
   ) dut (
      .pclk       (pclk),
      .reset      (reset),
      .ena_i      (ena_i),
      .jjoy_i     (jjoy_i),
      .kbd_joy_i  (kbd_joy_i),
      .jselect_o  (jselect_o),
      .joy_o      (joy_o),
      .scan_done_o(scan_done_o)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: enabled-cycle count since reset, per-player state.
   int         ecnt;
   bit         last_wrap;
   logic [7:0] mjoy [N];
   int         mcnt [N][8];
   int         cyc = 0;
   int         last_pulse;
   int         want_period;
   logic [7:0]     j_cur;
   logic [N*8-1:0] k_cur;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ecnt      = 0;
      last_wrap = 1'b0;
      for (int p = 0; p < N; p++) begin
         mjoy[p] = 8'hFF;
         for (int b = 0; b < 8; b++) mcnt[p][b] = 0;
      end
   endtask

   function automatic logic [N*8-1:0] model_joy();
      logic [N*8-1:0] v;
      for (int p = 0; p < N; p++) v[8*p +: 8] = mjoy[p];
      return v;
   endfunction

   task automatic model_edge(input logic e, input logic [7:0] j, input logic [N*8-1:0] k);
      int p;
      logic [7:0] raw;
      if (!e) return;
      p = (ecnt / SLOT) % N;
      if (ecnt % SLOT == S) begin
         raw = j & k[8*p +: 8];
         for (int b = 0; b < 8; b++) begin
            if (raw[b] == mjoy[p][b]) mcnt[p][b] = 0;
            else begin
               mcnt[p][b]++;
               if (mcnt[p][b] >= DEFF) begin
                  mjoy[p][b] = raw[b];
                  mcnt[p][b] = 0;
               end
            end
         end
         last_wrap = (p == N - 1);
      end else begin
         last_wrap = 1'b0;
      end
      ecnt++;
   endtask

   // One pclk cycle: drive, check mid-cycle, then advance model on the edge.
   task automatic cycle(input logic e, input logic [7:0] j, input logic [N*8-1:0] k);
      ena_i     = e;
      jjoy_i    = j;
      kbd_joy_i = k;
      @(negedge pclk);
      check("jselect", jselect_o, (ecnt / SLOT) % N);
      check("joy", joy_o, model_joy());
      check("scan_done", scan_done_o, last_wrap && e);
      if (scan_done_o === 1'b1) begin
         if (last_pulse >= 0 && want_period != 0) check("scan_period", cyc - last_pulse, want_period);
         last_pulse = cyc;
      end
      @(posedge pclk);
      model_edge(e, j, k);
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, j_cur, k_cur);
   endtask

   task automatic run_to(input int pos);
      for (int i = 0; i < SCAN && (ecnt % SCAN) != pos; i++) cycle(1'b1, j_cur, k_cur);
   endtask

   initial begin
      reset     = 1'b1;
      ena_i     = 1'b0;
      jjoy_i    = 8'hFF;
      kbd_joy_i = '1;
      j_cur     = 8'hFF;
      k_cur     = '1;
      last_pulse  = -1;
      want_period = 0;
      model_reset();
      #1;
      check("reset_joy", joy_o, 16'hFFFF);
      check("reset_sel", jselect_o, 0);
      check("reset_done", scan_done_o, 0);
      #2 reset = 1'b0;
      @(posedge pclk);
      #1;

      // Free-running scan: select 0,0,0,1,1,1 and a pulse every 6 cycles.
      want_period = SCAN;
      run(4 * SCAN);
      check("pulses_seen_ena1", (last_pulse >= 0), 1);
      want_period = 0;

      // Single glitch on player 1's sample slot.
      run_to(SCAN - 1);
      cycle(1'b1, 8'hFE, k_cur);
      check("p1_sample_load", joy_o, DB_EN ? 16'hFFFF : 16'hFEFF);
      run(2 * SCAN);

      // AND merge of keyboard and JAMMA bits.
      k_cur = 16'hFFEF;
      run(3 * SCAN);
      check("and_merge", joy_o[7:0], 8'hEF);
      k_cur = '1;
      run(3 * SCAN);

      // Debounce: two low scans then release, then three low scans.
      run_to(0);
      j_cur = 8'hFE;
      run(2 * SCAN);
      check("bit0_after_2_low", joy_o[0], DB_EN ? 1'b1 : 1'b0);
      j_cur = 8'hFF;
      run(SCAN);
      check("bit0_glitch_rejected", joy_o[0], 1'b1);
      j_cur = 8'hFE;
      run(2 * SCAN);
      check("bit0_2nd_of_3", joy_o[0], DB_EN ? 1'b1 : 1'b0);
      run(SCAN);
      check("bit0_after_3_low", joy_o[0], 1'b0);
      j_cur = 8'hFF;
      run(3 * SCAN);

      // Enable toggling 1,0: scan period doubles, pulse stays one cycle.
      last_pulse  = -1;
      want_period = 2 * SCAN;
      for (int i = 0; i < 8 * SCAN; i++) cycle(i[0] == 1'b0, j_cur, k_cur);
      check("pulses_seen_toggle", (last_pulse >= 0), 1);
      want_period = 0;

      // Randomized enable, slowly changing JAMMA bits, occasional keyboard changes.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) j_cur[$urandom_range(0, 7)] ^= 1'b1;
         if ($urandom_range(0, 31) == 0) k_cur = $urandom();
         cycle($urandom_range(0, 3) != 0, j_cur, k_cur);
      end

      // Reset pulsed during player 1's SETTLE.
      j_cur = 8'hFF;
      k_cur = 16'h5A5A;
      run(4 * SCAN);
      check("pre_reset_joy", joy_o, 16'h5A5A);
      run_to(SLOT);
      cycle(1'b1, j_cur, k_cur);
      check("pre_reset_sel", jselect_o, 1);
      reset = 1'b1;
      #1;
      check("async_reset_joy", joy_o, 16'hFFFF);
      check("async_reset_sel", jselect_o, 0);
      check("async_reset_done", scan_done_o, 0);
      model_reset();
      #1 reset = 1'b0;
      k_cur = '1;
      run(2 * SCAN);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
